// File: rtl/obs_pad_pkg.sv
// Shared types and constants for the observation pad scheduler.
// The PAR state is only reached when OBS_PAD_PARITY_EN is defined.
package obs_pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ID,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Serial bits per frame: start + ID + payload + optional parity + stop.
    function automatic int frame_len(input int id_w, input int data_w, input bit parity);
        return 2 + id_w + data_w + (parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/obs_pad_sched_rr_arb.sv
// Round-robin arbiter for the observation pad scheduler.
// The pick is combinational. The priority pointer is registered and
// moves to one past the winner only when the grant is taken.
module obs_pad_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               take_i,
    output logic               grant_valid_o,
    output logic [ID_W-1:0]    grant_id_o,
    output logic [NUM_REQ-1:0] grant_oh_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;

    // Pick the first active requester, starting the scan at the pointer.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the block leaves one unassigned and infers a latch.
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid_o && req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
        grant_oh_o = grant_valid_o ? (NUM_REQ'(1) << grant_id_o) : '0;
        ptr_d      = (grant_id_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_o + 1'b1;
    end

    // Advance the priority pointer past the requester that was just served.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before the edge.
        if (rst_i) begin
            ptr_q <= '0;
        end else if (take_i && grant_valid_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/obs_pad_sched.sv
// Observation pad scheduler. Requesters are picked round-robin and each
// accepted word goes out on one pad as: start, ID (LSB first),
// payload (LSB first), [parity], stop. Every bit lasts DIV cycles.
// Defining OBS_PAD_PARITY_EN inserts an even-parity bit over ID and payload.
module obs_pad_sched
    import obs_pad_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DIV     = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic                      pad_o,
    output logic                      busy_o,
    output logic [ID_W-1:0]           grant_id_o
);

    localparam int SH_W  = ID_W + DATA_W;
    localparam int MAX_W = (ID_W > DATA_W) ? ID_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int DIV_W = $clog2(DIV + 1);

    state_e             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [CNT_W-1:0]   bit_q;
    logic [SH_W-1:0]    sh_q;
    logic               pad_q;
    logic               busy_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [ID_W-1:0]    gid_q;
`ifdef OBS_PAD_PARITY_EN
    logic               par_q;
`endif

    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant_oh;
    logic               take;
    logic               div_tc;
    logic               shift_en;
    logic [DATA_W-1:0]  grant_data;

    assign take       = (state_q == ST_IDLE);
    assign div_tc     = (div_q == DIV_W'(DIV - 1));
    assign shift_en   = div_tc && (state_q inside {ST_START, ST_ID, ST_DATA});
    assign grant_data = data_i[int'(grant_id)*DATA_W +: DATA_W];

    obs_pad_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk_i         (wb_clk_i),
        .rst_i         (wb_rst_i),
        .req_i         (req_i),
        .take_i        (take),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id),
        .grant_oh_o    (grant_oh)
    );

    // Shift register: load {payload, ID} on grant, shift at the end of every bit.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: this datapath register is not reset; it is always loaded before any of its bits reach the pad.
        if (take && grant_valid) begin
            sh_q <= {grant_data, grant_id};
`ifdef OBS_PAD_PARITY_EN
            par_q <= ^{grant_data, grant_id};
`endif
        end else if (shift_en) begin
            sh_q <= sh_q >> 1;
        end
    end

    // Frame FSM with bit divider; all outputs come straight from registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            pad_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            gid_q   <= '0;
        end else begin
            ack_q <= '0;
            if (state_q == ST_IDLE) begin
                div_q <= '0;
            end else begin
                div_q <= div_tc ? '0 : div_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    pad_q  <= IDLE_LEVEL;
                    busy_q <= 1'b0;
                    if (grant_valid) begin
                        ack_q   <= grant_oh;
                        gid_q   <= grant_id;
                        pad_q   <= START_BIT;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (div_tc) begin
                        pad_q   <= sh_q[0];
                        state_q <= ST_ID;
                    end
                end
                ST_ID: begin
                    if (div_tc) begin
                        pad_q <= sh_q[0];
                        if (bit_q == CNT_W'(ID_W - 1)) begin
                            bit_q   <= '0;
                            state_q <= ST_DATA;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (div_tc) begin
                        if (bit_q == CNT_W'(DATA_W - 1)) begin
                            bit_q <= '0;
`ifdef OBS_PAD_PARITY_EN
                            pad_q   <= par_q;
                            state_q <= ST_PAR;
`else
                            pad_q   <= STOP_BIT;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            pad_q <= sh_q[0];
                        end
                    end
                end
`ifdef OBS_PAD_PARITY_EN
                ST_PAR: begin
                    if (div_tc) begin
                        pad_q   <= STOP_BIT;
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (div_tc) begin
                        pad_q   <= IDLE_LEVEL;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    pad_q   <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o      = ack_q;
    assign pad_o      = pad_q;
    assign busy_o     = busy_q;
    assign grant_id_o = gid_q;

endmodule

// File: tb/tb_obs_pad_sched.sv
// Self-checking bench for obs_pad_sched: a frame-level reference model
// compared on every cycle, directed scenarios with literal expectations,
// and a randomized requester phase.
`timescale 1ns/1ps
module tb_obs_pad_sched;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int DV = 16;
    localparam int IW = 2;

    logic            clk  = 1'b0;
    logic            rst  = 1'b1;
    logic [NR-1:0]   req  = '0;
    logic [NR*DW-1:0] data = '0;
    logic [NR-1:0]   ack;
    logic            pad;
    logic            busy;
    logic [IW-1:0]   gid;

    // Second instance: NUM_REQ=2, DATA_W=1, DIV=1.
    logic [1:0] req2  = '0;
    logic [1:0] data2 = '0;
    logic [1:0] ack2;
    logic       pad2;
    logic       busy2;
    logic       gid2;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    int cyc = 0;

    obs_pad_sched #(.NUM_REQ(NR), .DATA_W(DW), .DIV(DV)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req_i      (req),
        .data_i     (data),
        .ack_o      (ack),
        .pad_o      (pad),
        .busy_o     (busy),
        .grant_id_o (gid)
    );

    obs_pad_sched #(.NUM_REQ(2), .DATA_W(1), .DIV(1)) dut2 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req_i      (req2),
        .data_i     (data2),
        .ack_o      (ack2),
        .pad_o      (pad2),
        .busy_o     (busy2),
        .grant_id_o (gid2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A granted frame becomes a list of pad levels, one entry per clock.
    bit            mq[$];
    logic          m_pad  = 1'b1;
    logic          m_busy = 1'b0;
    logic [NR-1:0] m_ack  = '0;
    logic [IW-1:0] m_gid  = '0;
    int            m_ptr  = 0;
    int            m_pick;
    bit            m_par;

    function automatic void add_bit(input bit b);
        for (int r = 0; r < DV; r++) mq.push_back(b);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ptr = 0; m_gid = '0; m_ack = '0; m_pad = 1'b1; m_busy = 1'b0;
        end else begin
            m_ack = '0;
            if (!m_busy && req != '0) begin
                m_pick = -1;
                for (int i = 0; i < NR; i++)
                    if (m_pick < 0 && req[(m_ptr + i) % NR]) m_pick = (m_ptr + i) % NR;
                m_par = 1'b0;
                add_bit(1'b0);
                for (int i = 0; i < IW; i++) begin
                    add_bit(((m_pick >> i) & 1) != 0);
                    m_par ^= ((m_pick >> i) & 1) != 0;
                end
                for (int i = 0; i < DW; i++) begin
                    add_bit(data[m_pick*DW + i]);
                    m_par ^= data[m_pick*DW + i];
                end
`ifdef OBS_PAD_PARITY_EN
                add_bit(m_par);
`endif
                add_bit(1'b1);
                m_ack[m_pick] = 1'b1;
                m_gid = IW'(m_pick);
                m_ptr = (m_pick + 1) % NR;
            end
            if (mq.size() > 0) begin
                m_pad  = mq.pop_front();
                m_busy = 1'b1;
            end else begin
                m_pad  = 1'b1;
                m_busy = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (cmp_en)
            check("outputs{pad,busy,ack,gid}", 64'({pad, busy, ack, gid}),
                  64'({m_pad, m_busy, m_ack, m_gid}));
    end

    // ---------------- helpers ----------------
    task automatic wait_ack(input int budget, output int who);
        who = -1;
        for (int n = 0; n < budget && who < 0; n++) begin
            @(negedge clk);
            for (int k = 0; k < NR; k++) if (ack[k]) who = k;
        end
        if (who < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_wait @%0t: no ack within %0d cycles", $time, budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_wait @%0t: busy still %0b after %0d cycles", $time, busy, budget);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    bit   pads[200];
    int   bcnt, who, c0, ack3_cnt;
    int   order[5];
    int   tack[5];
    bit   p2[6];
    bit   exp_a5[12] = '{0, 0,0, 1,0,1,0,0,1,0,1, 1};
    int   exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_pad", 64'(pad), 64'(1));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_ack", 64'(ack), 64'(0));
        check("reset_gid", 64'(gid), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single request, payload A5 from requester 0.
        data[7:0] = 8'hA5;
        req = 4'b0001;
        c0 = cyc;
        wait_ack(5, who);
        check("single_ack_id", 64'(who), 64'(0));
        check("single_ack_latency", 64'(cyc - c0), 64'(1));
        req = '0;
        bcnt = 0;
        for (int j = 0; j < 200; j++) begin
            if (j > 0) @(negedge clk);
            pads[j] = pad;
            if (busy) bcnt++;
        end
        for (int b = 0; b < 12; b++)
            check($sformatf("a5_bit%0d", b), 64'(pads[b*DV + DV/2]), 64'(exp_a5[b]));
        check("a5_bit_last_cycle", 64'(pads[2*DV - 1]), 64'(0));
        check("a5_busy_cycles", 64'(bcnt), 64'(192));

        // DIV=1, DATA_W=1, NUM_REQ=2: requester 1 sends bit 1.
        data2 = 2'b10;
        req2  = 2'b10;
        who = -1;
        for (int n = 0; n < 5 && who < 0; n++) begin
            @(negedge clk);
            if (ack2 != '0) who = int'(ack2);
        end
        check("small_ack", 64'(who), 64'(2));
        req2 = '0;
        bcnt = 0;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clk);
            p2[j] = pad2;
            if (busy2) bcnt++;
        end
        check("small_pad_seq", 64'({p2[0], p2[1], p2[2], p2[3], p2[4]}), 64'(5'b01111));
        check("small_busy_cycles", 64'(bcnt), 64'(4));
        check("small_gid", 64'(gid2), 64'(1));

        // All four requesting continuously, starting from a fresh pointer.
        wait_idle(400);
        pulse_reset();
        for (int k = 0; k < NR; k++) data[k*DW +: DW] = DW'($urandom);
        req = 4'b1111;
        for (int a = 0; a < 5; a++) begin
            wait_ack(400, who);
            order[a] = who;
            tack[a]  = cyc;
            if (who >= 0) data[who*DW +: DW] = DW'($urandom);
        end
        req = '0;
        for (int a = 0; a < 5; a++)
            check($sformatf("rr_order%0d", a), 64'(order[a]), 64'(exp_order[a]));
        for (int a = 1; a < 5; a++)
            check($sformatf("rr_interval%0d", a), 64'(tack[a] - tack[a-1]), 64'(12*DV + 1));

        // Reset in the middle of a frame (cycle 50), with requests pending.
        wait_idle(400);
        data[15:8] = 8'h3C;
        req = 4'b0010;
        wait_ack(5, who);
        check("pre_reset_ack", 64'(who), 64'(1));
        req = '0;
        repeat (49) @(negedge clk);
        req = 4'b1111;
        rst = 1'b1;
        @(negedge clk);
        check("midreset_pad", 64'(pad), 64'(1));
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_ack", 64'(ack), 64'(0));
        rst = 1'b0;
        wait_ack(5, who);
        check("post_reset_first_grant", 64'(who), 64'(0));
        req = '0;

        // Withdrawn request: requester 3 asks only while busy and drops before STOP.
        wait_idle(400);
        req = 4'b0001;
        wait_ack(5, who);
        req = '0;
        repeat (20) @(negedge clk);
        req[3] = 1'b1;
        repeat (50) @(negedge clk);
        req[3] = 1'b0;
        ack3_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (ack[3]) ack3_cnt++;
        end
        check("withdrawn_no_ack", 64'(ack3_cnt), 64'(0));
        check("withdrawn_idle", 64'(busy), 64'(0));

        // Randomized requesters following the handshake rules.
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            for (int k = 0; k < NR; k++) begin
                if (req[k] && ack[k]) begin
                    if ($urandom_range(1, 0) == 0) req[k] = 1'b0;
                    else data[k*DW +: DW] = DW'($urandom);
                end else if (req[k]) begin
                    if ($urandom_range(63, 0) == 0) req[k] = 1'b0;
                end else if ($urandom_range(7, 0) == 0) begin
                    data[k*DW +: DW] = DW'($urandom);
                    req[k] = 1'b1;
                end
            end
        end
        req = '0;
        wait_idle(400);
        repeat (3) @(negedge clk);
        check("final_idle_pad", 64'(pad), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
